regfile_wb_arbiter: RTL and testbench

//  Sole arbiter/scheduler for the register-file write port. Accepts write requests from ALU, load/store and
//  PC-link sources via valid/ready, grants one per cycle round-robin, drives one registered write port.

---
 rtl/regfile_wb_arbiter_pkg.sv | 30 +++
 rtl/regfile_wb_arbiter_if.sv | 65 ++++++
 rtl/regfile_wb_arbiter_rr.sv | 71 +++++++
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Contents:
//   wb_src_e          writeback source identifiers, also used as the round-robin pointer
//   BE_W, BE_FULL     byte-enable width and the all-bytes enable
//   LINK_REG_DEFAULT  default link register for PC writes with pc_link=1
//   be_legal()        1 when a load byte-enable pattern is a supported lane combination
package regfile_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LD  = 2'd1,
        SRC_PC  = 2'd2
    } wb_src_e;

    localparam int         BE_W             = 4;
    localparam logic [3:0] BE_FULL          = 4'hF;
    localparam int         LINK_REG_DEFAULT = 31;

    // Supported patterns are single bytes, aligned halves, and the two
    // contiguous 3-byte groups, plus the full word.
    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b0111, 4'b1110,
            4'b1111: be_legal = 1'b1;
            default: be_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback requesters / issue stage and the
// register-file writeback arbiter.
// Signals:
//   alu_*, ld_*, pc_*        valid/ready write requests from the three sources
//   claim_valid/claim_addr   issue stage reserving a destination register
//   chk_rs/chk_rt, hazard_*  source hazard lookup against the busy scoreboard
//   wr_en/addr/data/be       registered register-file write port
//   be_err                   pulse when a load with illegal byte enables is dropped
// Modports: master = requester/issue side, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [3:0]        ld_be;

    logic              pc_valid;
    logic              pc_ready;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_link;
    logic [DATA_W-1:0] pc_data;

    logic              claim_valid;
    logic [ADDR_W-1:0] claim_addr;
    logic [ADDR_W-1:0] chk_rs;
    logic [ADDR_W-1:0] chk_rt;
    logic              hazard_rs;
    logic              hazard_rt;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_be;
    logic              be_err;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data, ld_be,
        output pc_valid, pc_addr, pc_link, pc_data,
        output claim_valid, claim_addr, chk_rs, chk_rt,
        input  alu_ready, ld_ready, pc_ready,
        input  hazard_rs, hazard_rt,
        input  wr_en, wr_addr, wr_data, wr_be, be_err
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data, ld_be,
        input  pc_valid, pc_addr, pc_link, pc_data,
        input  claim_valid, claim_addr, chk_rs, chk_rt,
        output alu_ready, ld_ready, pc_ready,
        output hazard_rs, hazard_rt,
        output wr_en, wr_addr, wr_data, wr_be, be_err
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// wb_rr_arbiter: 3-way writeback arbiter, at most one grant per cycle.
// Ports:
//   clk, rst  clock and synchronous active-high reset (no grants while rst=1)
//   req[2:0]  request vector, bit0=ALU, bit1=LD, bit2=PC
//   grant     one-hot grant, combinational from req and the pointer
// Default: round-robin ALU->LD->PC, pointer moves to the source after the winner.
// Macro REGFILE_WB_FIXED_PRIO_EN: fixed priority ALU > LD > PC, no pointer.
module wb_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] grant
);

`ifdef REGFILE_WB_FIXED_PRIO_EN

    always_comb begin
        grant = 3'b000;
        if (!rst) begin
            if (req[0])      grant = 3'b001;
            else if (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
        end
    end

`else

    wb_src_e ptr_q;
    wb_src_e ptr_d;

    // The pointer names the source that gets first look this cycle.
    always_comb begin
        grant = 3'b000;
        if (!rst) begin
            case (ptr_q)
                SRC_LD: begin
                    if (req[1])      grant = 3'b010;
                    else if (req[2]) grant = 3'b100;
                    else if (req[0]) grant = 3'b001;
                end
                SRC_PC: begin
                    if (req[2])      grant = 3'b100;
                    else if (req[0]) grant = 3'b001;
                    else if (req[1]) grant = 3'b010;
                end
                default: begin
                    if (req[0])      grant = 3'b001;
                    else if (req[1]) grant = 3'b010;
                    else if (req[2]) grant = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant[0])      ptr_d = SRC_LD;
        else if (grant[1]) ptr_d = SRC_PC;
        else if (grant[2]) ptr_d = SRC_ALU;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= SRC_ALU;
        else     ptr_q <= ptr_d;
    end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole scheduler for the register-file write port.
// Accepts ALU, load and PC-link writes over valid/ready, grants one per cycle
// and drives a registered write port one cycle after the transfer. A busy
// scoreboard lets the issue stage stall on RAW hazards against pending writes.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       regfile_wb_arbiter_if.slave (requests, claims, hazard lookup, write port)
// Parameters: ADDR_W, DATA_W, LINK_REG (destination of PC writes with pc_link=1).
// Macro REGFILE_WB_FIXED_PRIO_EN selects fixed priority arbitration in wb_rr_arbiter.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int LINK_REG = LINK_REG_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int NREG = 1 << ADDR_W;

    logic [2:0]        req;
    logic [2:0]        grant;
    logic [ADDR_W-1:0] pc_dest;
    logic [ADDR_W-1:0] dest;
    logic              accept_write;

    logic              wr_en_d,   wr_en_q;
    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
    logic [DATA_W-1:0] wr_data_d, wr_data_q;
    logic [BE_W-1:0]   wr_be_d,   wr_be_q;
    logic              be_err_d,  be_err_q;
    logic [NREG-1:0]   busy_d,    busy_q;

    assign req = {bus.pc_valid, bus.ld_valid, bus.alu_valid};

    wb_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    assign bus.alu_ready = grant[0];
    assign bus.ld_ready  = grant[1];
    assign bus.pc_ready  = grant[2];

    assign pc_dest = bus.pc_link ? ADDR_W'(LINK_REG) : bus.pc_addr;

    // A load with an illegal byte-enable pattern is still handshaken so the
    // source never deadlocks, but it only produces the error pulse.
    // Writes to register 0 are accepted and silently discarded.
    always_comb begin
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        wr_be_d      = '0;
        be_err_d     = 1'b0;
        dest         = '0;
        accept_write = 1'b0;
        if (grant[0]) begin
            dest         = bus.alu_addr;
            accept_write = 1'b1;
            wr_data_d    = bus.alu_data;
            wr_be_d      = BE_FULL;
        end else if (grant[1]) begin
            if (be_legal(bus.ld_be)) begin
                dest         = bus.ld_addr;
                accept_write = 1'b1;
                wr_data_d    = bus.ld_data;
                wr_be_d      = bus.ld_be;
            end else begin
                be_err_d = 1'b1;
            end
        end else if (grant[2]) begin
            dest         = pc_dest;
            accept_write = 1'b1;
            wr_data_d    = bus.pc_data;
            wr_be_d      = BE_FULL;
        end
        if (accept_write && (dest != '0)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dest;
        end else begin
            wr_data_d = '0;
            wr_be_d   = '0;
        end
    end

    // Claim is applied after the clear so a same-cycle claim and writeback to
    // one register leaves it busy for the newer producer.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_d)         busy_d[dest] = 1'b0;
        if (bus.claim_valid) busy_d[bus.claim_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
            be_err_q  <= 1'b0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_be_q   <= wr_be_d;
            be_err_q  <= be_err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_be   = wr_be_q;
    assign bus.be_err  = be_err_q;

    assign bus.hazard_rs = (bus.chk_rs != '0) && busy_q[bus.chk_rs];
    assign bus.hazard_rt = (bus.chk_rt != '0) && busy_q[bus.chk_rt];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change just after the falling edge; combinational readys/hazards are
// sampled 1ns later, registered outputs 1ns after the rising edge.
// Define REGFILE_WB_FIXED_PRIO_EN for both bench and RTL to check fixed priority.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_addr    = '0;
        bus.alu_data    = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.ld_be       = 4'hF;
        bus.pc_valid    = 1'b0;
        bus.pc_addr     = '0;
        bus.pc_link     = 1'b0;
        bus.pc_data     = '0;
        bus.claim_valid = 1'b0;
        bus.claim_addr  = '0;
        bus.chk_rs      = '0;
        bus.chk_rt      = '0;
    endtask

    task automatic drive_contention();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'h0000_00A1;
        bus.ld_valid  = 1'b1; bus.ld_addr  = 5'd2; bus.ld_data  = 32'h0000_00B2; bus.ld_be = 4'hF;
        bus.pc_valid  = 1'b1; bus.pc_addr  = 5'd4; bus.pc_data  = 32'h0000_00C4; bus.pc_link = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_contention();
        #1;
        checks++;
        if ({bus.pc_ready, bus.ld_ready, bus.alu_ready} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_readys: got %b expected 000", {bus.pc_ready, bus.ld_ready, bus.alu_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, bus.be_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got en=%b addr=%0d data=%h be=%h err=%b expected all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, bus.be_err);
        end
        checks++;
        if ({bus.hazard_rs, bus.hazard_rt} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_hazards: got %b expected 00", {bus.hazard_rs, bus.hazard_rt});
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_contention();
        logic [2:0]  exp_g [6];
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
`ifdef REGFILE_WB_FIXED_PRIO_EN
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        @(negedge clk);
        drive_contention();
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({bus.pc_ready, bus.ld_ready, bus.alu_ready} !== exp_g[i]) begin
                errors++;
                $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", i,
                         {bus.pc_ready, bus.ld_ready, bus.alu_ready}, exp_g[i]);
            end
            exp_addr = (exp_g[i] == 3'b001) ? 5'd1 : (exp_g[i] == 3'b010) ? 5'd2 : 5'd4;
            exp_data = (exp_g[i] == 3'b001) ? 32'hA1 : (exp_g[i] == 3'b010) ? 32'hB2 : 32'hC4;
            @(posedge clk); #1;
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== exp_addr || bus.wr_data !== exp_data || bus.wr_be !== 4'hF) begin
                errors++;
                $display("[TB] FAIL contention_write[%0d]: got en=%b addr=%0d data=%h be=%h expected en=1 addr=%0d data=%h be=f",
                         i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, exp_addr, exp_data);
            end
            @(negedge clk);
        end
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_wr_en: got %b expected 0", bus.wr_en);
        end
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'h0000_1234;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alu_ready: got %b expected 1", bus.alu_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'h1234 || bus.wr_be !== 4'hF) begin
            errors++;
            $display("[TB] FAIL alu_write: got en=%b addr=%0d data=%h be=%h expected en=1 addr=5 data=00001234 be=f",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be);
        end
    endtask

    task automatic test_pc_link();
        @(negedge clk);
        idle_inputs();
        bus.pc_valid = 1'b1; bus.pc_link = 1'b1; bus.pc_addr = 5'd3; bus.pc_data = 32'h0040_0010;
        #1;
        checks++;
        if (bus.pc_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pc_ready: got %b expected 1", bus.pc_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd31 || bus.wr_data !== 32'h0040_0010 || bus.wr_be !== 4'hF) begin
            errors++;
            $display("[TB] FAIL pc_link_write: got en=%b addr=%0d data=%h be=%h expected en=1 addr=31 data=00400010 be=f",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be);
        end
        @(negedge clk);
        bus.pc_link = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3) begin
            errors++;
            $display("[TB] FAIL pc_nolink_write: got en=%b addr=%0d expected en=1 addr=3", bus.wr_en, bus.wr_addr);
        end
    endtask

    task automatic test_addr_zero();
        @(negedge clk);
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_ready: got %b expected 1", bus.alu_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_wr_en: got %b expected 0", bus.wr_en);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle_inputs();
        bus.chk_rs = 5'd7; bus.chk_rt = 5'd8;
        bus.claim_valid = 1'b1; bus.claim_addr = 5'd7;
        #1;
        checks++;
        if (bus.hazard_rs !== 1'b0) begin
            errors++;
            $display("[TB] FAIL claim_before_edge: got %b expected 0", bus.hazard_rs);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.hazard_rs !== 1'b1 || bus.hazard_rt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL claim_busy: got rs=%b rt=%b expected rs=1 rt=0", bus.hazard_rs, bus.hazard_rt);
        end
        @(negedge clk);
        bus.claim_valid = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd7; bus.ld_data = 32'h77; bus.ld_be = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (bus.hazard_rs !== 1'b0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7) begin
            errors++;
            $display("[TB] FAIL ld_clears_busy: got rs=%b en=%b addr=%0d expected rs=0 en=1 addr=7",
                     bus.hazard_rs, bus.wr_en, bus.wr_addr);
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.claim_valid = 1'b1; bus.claim_addr = 5'd7;
        @(negedge clk);
        bus.ld_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.hazard_rs !== 1'b1 || bus.wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL claim_wins: got rs=%b en=%b expected rs=1 en=1", bus.hazard_rs, bus.wr_en);
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.claim_addr = 5'd0; bus.chk_rt = 5'd0;
        @(posedge clk); #1;
        checks++;
        if (bus.hazard_rt !== 1'b0 || bus.hazard_rs !== 1'b1) begin
            errors++;
            $display("[TB] FAIL claim_zero: got rt=%b rs=%b expected rt=0 rs=1", bus.hazard_rt, bus.hazard_rs);
        end
        @(negedge clk);
        bus.claim_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h7;
        @(posedge clk); #1;
        checks++;
        if (bus.hazard_rs !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_clears_busy: got %b expected 0", bus.hazard_rs);
        end
    endtask

    task automatic test_bad_be();
        @(negedge clk);
        idle_inputs();
        bus.claim_valid = 1'b1; bus.claim_addr = 5'd9; bus.chk_rs = 5'd9;
        @(negedge clk);
        bus.claim_valid = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd9; bus.ld_data = 32'h9999; bus.ld_be = 4'b0101;
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_be_ready: got %b expected 1", bus.ld_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.be_err !== 1'b1 || bus.hazard_rs !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_be_drop: got en=%b err=%b busy=%b expected en=0 err=1 busy=1",
                     bus.wr_en, bus.be_err, bus.hazard_rs);
        end
        @(negedge clk);
        bus.ld_addr = 5'd10; bus.ld_data = 32'h5555; bus.ld_be = 4'b0011;
        @(posedge clk); #1;
        checks++;
        if (bus.be_err !== 1'b0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd10 || bus.wr_be !== 4'b0011 || bus.wr_data !== 32'h5555) begin
            errors++;
            $display("[TB] FAIL partial_be_write: got err=%b en=%b addr=%0d be=%b data=%h expected err=0 en=1 addr=10 be=0011 data=00005555",
                     bus.be_err, bus.wr_en, bus.wr_addr, bus.wr_be, bus.wr_data);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        bus.claim_valid = 1'b1; bus.claim_addr = 5'd12; bus.chk_rs = 5'd12;
        @(negedge clk);
        bus.claim_valid = 1'b0;
        drive_contention();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.pc_ready, bus.ld_ready, bus.alu_ready} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL mid_reset_readys: got %b expected 000", {bus.pc_ready, bus.ld_ready, bus.alu_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, bus.be_err, bus.hazard_rs} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got en=%b addr=%0d data=%h be=%h err=%b rs=%b expected all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, bus.be_err, bus.hazard_rs);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.pc_ready, bus.ld_ready, bus.alu_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL post_reset_grant: got %b expected 001", {bus.pc_ready, bus.ld_ready, bus.alu_ready});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        $display("[TB] starting regfile_wb_arbiter bench");
        test_reset();
        test_contention();
        test_alu_write();
        test_pc_link();
        test_addr_zero();
        test_scoreboard();
        test_bad_be();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
